eeprom_ram_arbiter: RTL
=======================

Name: eeprom_ram_arbiter

Overview:
- Shares one backing save-RAM port between the serial EEPROM model (24C01/24C02 emulation) and a host port used for save-file load/store and savestate sideband.
- The EEPROM side uses level requests held until done. The host side uses single-cycle request pulses. Memory uses a request-held-until-ack handshake with variable latency.
- Also maintains a dirty flag so the host knows when the save must be flushed.

Parameters:
ADDR_W, 8, width of all address buses (256 bytes covers 24C02)
TIMEOUT, 1024, cycles to wait for mem_ack before forced completion; 0 disables the timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
ee_addr  in  ADDR_W  EEPROM RAM address
ee_wdata  in  8  EEPROM write data
ee_read  in  1  EEPROM read request, level, held until ee_done seen
ee_write  in  1  EEPROM write request, level, held until ee_done seen
ee_rdata  out  8  read data returned to EEPROM
ee_done  out  1  completion, held high until the request level drops
host_addr  in  ADDR_W  host address
host_wdata  in  8  host write data
host_rd  in  1  host read pulse
host_wr  in  1  host write pulse
host_rdata  out  8  host read data
host_ack  out  1  one-cycle completion pulse
host_busy  out  1  host request pending or in service
dirty  out  1  set by any completed EEPROM write
clear_dirty  in  1  pulse: clear dirty
mem_addr  out  ADDR_W  backing RAM address
mem_wdata  out  8  backing RAM write data
mem_rd  out  1  read strobe, held until mem_ack
mem_wr  out  1  write strobe, held until mem_ack
mem_rdata  in  8  backing RAM read data, valid with mem_ack
mem_ack  in  1  backing RAM completion
timeout_err  out  1  sticky: a TIMEOUT expiry occurred; cleared only by reset

Behaviour:
- Reset: all outputs 0, except ee_rdata = 0xFF and host_rdata = 0xFF.
  - Reset also clears state, the host pending latch and the timeout counter.
  - Reset mid-access abandons the access; no ack or done is generated.
- Host latch:
  - host_rd or host_wr with host_busy = 0 captures addr, wdata and op into pending; host_busy rises next cycle.
  - Pulses arriving while host_busy = 1 are dropped.
  - host_rd and host_wr together are treated as a write.
- State IDLE:
  - EEPROM request (ee_read or ee_write) and no host pending -> EE_ACCESS.
  - Host pending and no EEPROM request -> HOST_ACCESS.
  - Both present: alternate. last_grant bit selects the side not served last; the bit resets to host so the EEPROM wins the first tie.
  - ee_read and ee_write together: write is performed.
- State EE_ACCESS:
  - mem_addr = ee_addr; mem_wr or mem_rd asserted from the entry cycle; mem_wdata = ee_wdata.
  - On mem_ack: drop the strobe; on a read, ee_rdata <= mem_rdata.
  - On mem_ack for a write, set dirty; if clear_dirty arrives in the same cycle, set wins.
  - Then ee_done <= 1 -> EE_RELEASE.
- State EE_RELEASE:
  - ee_done held at 1 while ee_read or ee_write is high, which tolerates the EEPROM's ce-gated sampling.
  - When both are low, ee_done <= 0 -> IDLE. The same request is never restarted.
- State HOST_ACCESS:
  - Same mem handshake with the pending latch contents.
  - On mem_ack: host_rdata updated (read only), host_ack pulses 1 cycle, pending cleared, -> IDLE.
- Timeout:
  - The counter starts at 0 on entry to either ACCESS state and increments each cycle without mem_ack.
  - Reaching TIMEOUT-1 with no ack: complete as if acked with read data 0xFF, set timeout_err, no dirty set.
- Latency with mem_ack in the cycle after the strobe rises:
  - EEPROM: request-to-done is 3 cycles.
  - Host: pulse-to-host_ack is 4 cycles.
- mem_rd/mem_wr are never high together and are never asserted outside the ACCESS states.
- mem_addr and mem_wdata are stable for the whole strobe.

Test Plan:
- EEPROM write addr 0x12 data 0xA5, mem_ack 1 cycle after strobe -> mem_wr with 0x12/0xA5; ee_done held until ee_write drops; dirty = 1.
- EEPROM read 0x7F, RAM holds 0x3C, ee_read held 10 cycles after done -> ee_rdata = 0x3C; exactly one mem_rd transaction; ee_done held 10 cycles.
- Simultaneous ee_read and host_wr 0x05 = 0x99, sustained requests -> grants EEPROM first, then host; host_ack pulses once; RAM[0x05] = 0x99.
- Second host_rd pulse while host_busy -> ignored; only one host_ack.
- mem_ack never asserted, TIMEOUT = 16 -> host_rdata 0xFF and host_ack at cycle 16; timeout_err = 1; dirty unchanged.
- Reset asserted during a mem_rd wait -> all strobes 0 next cycle; no done or ack; dirty = 0.

Source files
------------

// File: rtl/eeprom_ram_arbiter_if.sv
// Signal bundle between the save-RAM arbiter, its two requesters (EEPROM model, host)
// and the backing RAM. The arbiter takes the slave view; the environment takes master.
interface eeprom_ram_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] ee_addr;
  logic [7:0]        ee_wdata;
  logic              ee_read;
  logic              ee_write;
  logic [7:0]        ee_rdata;
  logic              ee_done;

  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_rd;
  logic              host_wr;
  logic [7:0]        host_rdata;
  logic              host_ack;
  logic              host_busy;

  logic              dirty;
  logic              clear_dirty;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  logic              timeout_err;

  modport slave (
    input  ee_addr, ee_wdata, ee_read, ee_write,
    output ee_rdata, ee_done,
    input  host_addr, host_wdata, host_rd, host_wr,
    output host_rdata, host_ack, host_busy,
    output dirty,
    input  clear_dirty,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ack,
    output timeout_err
  );

  modport master (
    output ee_addr, ee_wdata, ee_read, ee_write,
    input  ee_rdata, ee_done,
    output host_addr, host_wdata, host_rd, host_wr,
    input  host_rdata, host_ack, host_busy,
    input  dirty,
    output clear_dirty,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ack,
    input  timeout_err
  );
endinterface

// File: rtl/eeprom_ram_arbiter.sv
// Shares one save-RAM port between the serial EEPROM model and the host save port,
// alternating on ties, with a watchdog on the RAM handshake and a save-dirty flag.
module eeprom_ram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  eeprom_ram_arbiter_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, EE_ACCESS, EE_RELEASE, HOST_ACCESS} state_t;

  state_t            state, state_n;
  logic              last_grant_ee, last_grant_ee_n;
  logic              pend_valid, pend_valid_n;
  logic              pend_write, pend_write_n;
  logic [ADDR_W-1:0] pend_addr, pend_addr_n;
  logic [7:0]        pend_wdata, pend_wdata_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic [7:0]        mem_wdata_q, mem_wdata_n;
  logic              mem_rd_q, mem_rd_n;
  logic              mem_wr_q, mem_wr_n;
  logic [7:0]        ee_rdata_q, ee_rdata_n;
  logic              ee_done_q, ee_done_n;
  logic [7:0]        host_rdata_q, host_rdata_n;
  logic              host_ack_q, host_ack_n;
  logic              dirty_q, dirty_n;
  logic              timeout_err_q, timeout_err_n;
  logic              ee_req;
  logic              expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant_ee <= 1'b0;
      pend_valid    <= 1'b0;
      pend_write    <= 1'b0;
      pend_addr     <= '0;
      pend_wdata    <= '0;
      cnt           <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      ee_rdata_q    <= 8'hFF;
      ee_done_q     <= 1'b0;
      host_rdata_q  <= 8'hFF;
      host_ack_q    <= 1'b0;
      dirty_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state         <= state_n;
      last_grant_ee <= last_grant_ee_n;
      pend_valid    <= pend_valid_n;
      pend_write    <= pend_write_n;
      pend_addr     <= pend_addr_n;
      pend_wdata    <= pend_wdata_n;
      cnt           <= cnt_n;
      mem_addr_q    <= mem_addr_n;
      mem_wdata_q   <= mem_wdata_n;
      mem_rd_q      <= mem_rd_n;
      mem_wr_q      <= mem_wr_n;
      ee_rdata_q    <= ee_rdata_n;
      ee_done_q     <= ee_done_n;
      host_rdata_q  <= host_rdata_n;
      host_ack_q    <= host_ack_n;
      dirty_q       <= dirty_n;
      timeout_err_q <= timeout_err_n;
    end
  end

  // Strobes and address are registered at grant time so they stay glitch-free and
  // stable for the whole access; a timeout completes like an ack carrying 0xFF.
  always_comb begin
    state_n         = state;
    last_grant_ee_n = last_grant_ee;
    pend_valid_n    = pend_valid;
    pend_write_n    = pend_write;
    pend_addr_n     = pend_addr;
    pend_wdata_n    = pend_wdata;
    cnt_n           = cnt;
    mem_addr_n      = mem_addr_q;
    mem_wdata_n     = mem_wdata_q;
    mem_rd_n        = mem_rd_q;
    mem_wr_n        = mem_wr_q;
    ee_rdata_n      = ee_rdata_q;
    ee_done_n       = ee_done_q;
    host_rdata_n    = host_rdata_q;
    host_ack_n      = 1'b0;
    dirty_n         = dirty_q & ~bus.clear_dirty;
    timeout_err_n   = timeout_err_q;
    ee_req          = bus.ee_read | bus.ee_write;
    expired         = (TIMEOUT != 0) && !bus.mem_ack && (cnt == CNT_LAST);

    if (!pend_valid && (bus.host_rd || bus.host_wr)) begin
      pend_valid_n = 1'b1;
      pend_write_n = bus.host_wr;
      pend_addr_n  = bus.host_addr;
      pend_wdata_n = bus.host_wdata;
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (ee_req && (!pend_valid || !last_grant_ee)) begin
          state_n         = EE_ACCESS;
          last_grant_ee_n = 1'b1;
          mem_addr_n      = bus.ee_addr;
          mem_wdata_n     = bus.ee_wdata;
          mem_wr_n        = bus.ee_write;
          mem_rd_n        = ~bus.ee_write;
        end else if (pend_valid) begin
          state_n         = HOST_ACCESS;
          last_grant_ee_n = 1'b0;
          mem_addr_n      = pend_addr;
          mem_wdata_n     = pend_wdata;
          mem_wr_n        = pend_write;
          mem_rd_n        = ~pend_write;
        end
      end
      EE_ACCESS: begin
        if (bus.mem_ack || expired) begin
          state_n   = EE_RELEASE;
          mem_rd_n  = 1'b0;
          mem_wr_n  = 1'b0;
          ee_done_n = 1'b1;
          if (mem_rd_q) ee_rdata_n = bus.mem_ack ? bus.mem_rdata : 8'hFF;
          if (mem_wr_q && bus.mem_ack) dirty_n = 1'b1;
          if (!bus.mem_ack) timeout_err_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      EE_RELEASE: begin
        if (!ee_req) begin
          state_n   = IDLE;
          ee_done_n = 1'b0;
        end
      end
      HOST_ACCESS: begin
        if (bus.mem_ack || expired) begin
          state_n      = IDLE;
          mem_rd_n     = 1'b0;
          mem_wr_n     = 1'b0;
          host_ack_n   = 1'b1;
          pend_valid_n = 1'b0;
          if (mem_rd_q) host_rdata_n = bus.mem_ack ? bus.mem_rdata : 8'hFF;
          if (!bus.mem_ack) timeout_err_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.ee_rdata    = ee_rdata_q;
  assign bus.ee_done     = ee_done_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.host_busy   = pend_valid;
  assign bus.dirty       = dirty_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
